tensor_dot_accumulator: RTL and testbench
=========================================

Name: tensor_dot_accumulator

Overview:
- Downstream stage of the tensor multiplier (naivemultiplier) in the SM tensor pipeline.
- Consumes a stream of unsigned 2*LEN-bit products with valid/ready handshake and accumulates them into a dot-product sum.
- Emits one result per dot product, marked by in_last, into a held output register with its own valid/ready handshake.
- Accumulation of the next dot product overlaps with a stalled output.

Parameters:
- LEN, 32: operand width of the upstream multiplier; product width is 2*LEN.
- GUARD, 8: extra accumulator bits above the product width; ACC_W = 2*LEN+GUARD.
- MAX_K, 256: maximum beats per dot product; CNT_W = $clog2(MAX_K+1).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  product beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_product  input  2*LEN  unsigned product from multiplier
- in_last  input  1  final beat of current dot product
- init_en  input  1  on first beat, seed with acc_init instead of 0
- acc_init  input  ACC_W  seed value (bias/C operand), sampled on first beat only
- flush  input  1  synchronous abort of in-progress accumulation
- out_valid  output  1  result valid
- out_ready  input  1  result consumed when out_valid && out_ready
- out_sum  output  ACC_W  dot-product sum
- out_count  output  CNT_W  beats accumulated into out_sum
- out_overflow  output  1  sum wrapped or MAX_K forced termination

Behaviour:
- Reset (async, rst_n low): acc, cnt and ovf_acc are 0; out_valid, out_sum, out_count and out_overflow are 0. Reset mid-operation discards all partial and held results.
- State: accumulator acc[ACC_W], beat counter cnt[CNT_W] (0 = no beat yet), sticky ovf_acc, and an output register set {out_sum, out_count, out_overflow, out_valid}.
- in_ready = !out_valid || out_ready.
  - Combinational from output state only; never depends on in_valid or in_last.
  - Deasserted during flush.
- Accepted beat, first (cnt==0):
  - base = init_en ? acc_init : 0.
  - acc <= base + zext(in_product); ovf_acc <= carry out of ACC_W.
- Accepted beat, later (cnt>0):
  - acc <= acc + zext(in_product).
  - ovf_acc <= ovf_acc | carry.
  - Sums wrap modulo 2^ACC_W.
- cnt increments by 1 per accepted beat.
- A beat terminates the dot product if in_last=1, or if cnt==MAX_K-1 (the MAX_K-th beat).
  - Forced termination without in_last sets the result's overflow bit.
  - The next beat starts a new dot product.
- On a terminating beat in cycle N:
  - Load the output register with the final sum (including this beat), cnt+1, and the overflow OR.
  - out_valid=1 from cycle N+1.
  - acc, cnt and ovf_acc clear to 0 at the same edge.
- Latency: terminating beat accepted at cycle N -> out_valid at N+1. There is no combinational in->out path.
- Output handshake: out_valid && out_ready with no terminating beat clears out_valid at the next edge; out_sum, out_count and out_overflow hold their values.
- Simultaneous output handshake and terminating beat: the output register reloads with the new result and out_valid stays 1. Back-to-back results are supported at one per cycle.
- While out_valid && !out_ready: in_ready=0, so no beat is accepted, terminating or not. Output fields are stable while out_valid is 1.
- Single-beat dot product (in_last on the first beat): result is base + product, count=1.
- flush=1:
  - Clears acc, cnt and ovf_acc at the next edge; no beat is accepted that cycle.
  - A pending out_valid result is unaffected.
  - flush has priority over in_valid.

Decomposition:
- Package tensor_pkg holds:
  - the ACC_W and CNT_W derivation functions;
  - a result struct {sum, count, overflow};
  - shared localparams for LEN defaults.
- One sub-module, tensor_acc_result_reg: the output hold register with valid/ready and load-while-drain behaviour.
- The adder, counter and termination logic stay in the top.

Test Plan:
- LEN=8, GUARD=8, init_en=0, out_ready=1. Beats 3, 5, 7 (last on 7) -> one cycle later out_valid=1, out_sum=15, out_count=3, out_overflow=0.
- init_en=1, acc_init=100, beats 2, 3 (last) -> out_sum=105, out_count=2. A following dot product of 4 (last) with init_en=0 -> out_sum=4, count=1, delivered back-to-back.
- Backpressure:
  - Hold out_ready=0 after result 15 is pending; offer beats 1, 2 (last) -> in_ready=0, both beats wait, out fields stay 15/3.
  - Raise out_ready -> 15 drains; the beats are then accepted, and the second result out_sum=3, count=2 follows one cycle after 2 is accepted.
- Overflow, GUARD=0 (ACC_W=16):
  - Beats 0xFFFF, 0x0002 (last) -> out_sum=0x0001, out_overflow=1.
  - MAX_K=4 with five beats of 1 and no in_last -> first result sum=4, count=4, overflow=1. The fifth beat starts a new dot product.
- Flush after beats 10, 20 -> the next dot product 5 (last) gives sum=5, count=1. A flush asserted while a result is held leaves that result intact.
- Assert rst_n=0 mid-accumulation and with out_valid=1 -> all outputs 0 immediately. After release, beats 6 (last) -> sum=6, count=1.

Source files
------------

// File: rtl/tensor_pkg.sv
// Shared widths, defaults and result record for the SM tensor accumulate stage.
package tensor_pkg;

    localparam int LEN_DEFAULT   = 32;
    localparam int GUARD_DEFAULT = 8;
    localparam int MAX_K_DEFAULT = 256;

    function automatic int acc_width(input int len, input int guard);
        return 2 * len + guard;
    endfunction

    function automatic int cnt_width(input int max_k);
        return $clog2(max_k + 1);
    endfunction

    localparam int ACC_W_DEFAULT = acc_width(LEN_DEFAULT, GUARD_DEFAULT);
    localparam int CNT_W_DEFAULT = cnt_width(MAX_K_DEFAULT);

    // Result record at the default configuration; other configurations
    // declare the same layout with their own widths.
    typedef struct packed {
        logic [ACC_W_DEFAULT-1:0] sum;
        logic [CNT_W_DEFAULT-1:0] count;
        logic                     overflow;
    } result_t;

endpackage

// File: rtl/tensor_acc_result_reg.sv
// Output hold register: holds one dot-product result under valid/ready and
// can be reloaded in the same cycle it is drained.
module tensor_acc_result_reg
    import tensor_pkg::*;
#(
    parameter type rec_t = tensor_pkg::result_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  rec_t load_result,
    input  logic drain,
    output logic valid,
    output rec_t result,
    output logic ready
);

    // Space is available when nothing is held or the held result leaves now.
    assign ready = !valid || drain;

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values; the async reset clears both flag and payload
    // so a reset never exposes a stale result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            result <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            result <= load_result;
        end else if (valid && drain) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/tensor_dot_accumulator.sv
// Accumulates a stream of unsigned products into dot-product sums and hands
// each finished sum to a held output register.
module tensor_dot_accumulator
    import tensor_pkg::*;
#(
    parameter  int LEN   = LEN_DEFAULT,
    parameter  int GUARD = GUARD_DEFAULT,
    parameter  int MAX_K = MAX_K_DEFAULT,
    localparam int ACC_W = acc_width(LEN, GUARD),
    localparam int CNT_W = cnt_width(MAX_K)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*LEN-1:0] in_product,
    input  logic             in_last,
    input  logic             init_en,
    input  logic [ACC_W-1:0] acc_init,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             overflow;
    } acc_result_t;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

    logic             res_ready;
    logic             accept;
    logic             first_beat;
    logic             last_slot;
    logic             terminate;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_ext;
    logic             ovf_next;
    logic [CNT_W-1:0] cnt_next;
    acc_result_t      new_result;
    acc_result_t      held_result;

    assign in_ready   = res_ready && !flush;
    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt == '0);
    assign last_slot  = (cnt == CNT_W'(MAX_K - 1));
    assign terminate  = in_last || last_slot;

    // The first beat of a dot product starts from the seed, not the stale sum.
    assign base     = first_beat ? (init_en ? acc_init : '0) : acc;
    assign sum_ext  = {1'b0, base} + (ACC_W + 1)'(in_product);
    assign ovf_next = (ovf_acc && !first_beat) || sum_ext[ACC_W];
    assign cnt_next = cnt + 1'b1;

    always_comb begin
        new_result          = '0;
        new_result.sum      = sum_ext[ACC_W-1:0];
        new_result.count    = cnt_next;
        new_result.overflow = ovf_next || (last_slot && !in_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (flush || (accept && terminate)) begin
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else if (accept) begin
            acc     <= sum_ext[ACC_W-1:0];
            cnt     <= cnt_next;
            ovf_acc <= ovf_next;
        end
    end

    tensor_acc_result_reg #(
        .rec_t(acc_result_t)
    ) u_result_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept && terminate),
        .load_result(new_result),
        .drain      (out_ready),
        .valid      (out_valid),
        .result     (held_result),
        .ready      (res_ready)
    );

    assign out_sum      = held_result.sum;
    assign out_count    = held_result.count;
    assign out_overflow = held_result.overflow;

endmodule

// File: tb/tb_tensor_dot_accumulator.sv
// Bench for tensor_dot_accumulator: two configurations share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_tensor_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        init_en = 1'b0;
    logic [23:0] acc_init = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_out_overflow;
    logic [23:0] a_out_sum;
    logic [8:0]  a_out_count;
    logic        b_in_ready, b_out_valid, b_out_overflow;
    logic [15:0] b_out_sum;
    logic [2:0]  b_out_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tensor_dot_accumulator #(.LEN(8), .GUARD(8), .MAX_K(256)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_product(in_product), .in_last(in_last), .init_en(init_en),
        .acc_init(acc_init), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_sum(a_out_sum), .out_count(a_out_count),
        .out_overflow(a_out_overflow)
    );

    tensor_dot_accumulator #(.LEN(8), .GUARD(0), .MAX_K(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_product(in_product), .in_last(in_last), .init_en(init_en),
        .acc_init(acc_init[15:0]), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_sum(b_out_sum), .out_count(b_out_count),
        .out_overflow(b_out_overflow)
    );

    // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) -------
    function automatic int acc_w_of(input int d);
        return (d == 0) ? 24 : 16;
    endfunction

    function automatic int max_k_of(input int d);
        return (d == 0) ? 256 : 4;
    endfunction

    longint m_acc[2];
    int     m_cnt[2];
    bit     m_ovf[2];
    bit     m_ov[2];
    longint m_sum[2];
    int     m_count[2];
    bit     m_oo[2];

    longint mask, base, s;
    bit     o, forced;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_acc[d] <= 0; m_cnt[d] <= 0; m_ovf[d] <= 0;
                m_ov[d] <= 0; m_sum[d] <= 0; m_count[d] <= 0; m_oo[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mask = (longint'(1) << acc_w_of(d)) - 1;
                if (m_ov[d] && out_ready) m_ov[d] <= 0;
                if (flush) begin
                    m_acc[d] <= 0; m_cnt[d] <= 0; m_ovf[d] <= 0;
                end else if (in_valid && (!m_ov[d] || out_ready)) begin
                    if (m_cnt[d] == 0) base = init_en ? (longint'(acc_init) & mask) : 0;
                    else               base = m_acc[d];
                    s = base + longint'(in_product);
                    o = ((m_cnt[d] != 0) && m_ovf[d]) || ((s >> acc_w_of(d)) != 0);
                    s = s & mask;
                    forced = (m_cnt[d] + 1 == max_k_of(d)) && !in_last;
                    if (in_last || forced) begin
                        m_sum[d] <= s; m_count[d] <= m_cnt[d] + 1;
                        m_oo[d] <= o || forced; m_ov[d] <= 1;
                        m_acc[d] <= 0; m_cnt[d] <= 0; m_ovf[d] <= 0;
                    end else begin
                        m_acc[d] <= s; m_cnt[d] <= m_cnt[d] + 1; m_ovf[d] <= o;
                    end
                end
            end
        end
    end

    // ---------------- checking ---------------------------------------------
    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int d, input string tag, input longint rdy,
                           input longint vld, input longint sm,
                           input longint cn, input longint ov);
        check({tag, ".in_ready"},     rdy, longint'((!m_ov[d] || out_ready) && !flush));
        check({tag, ".out_valid"},    vld, longint'(m_ov[d]));
        check({tag, ".out_sum"},      sm,  m_sum[d]);
        check({tag, ".out_count"},    cn,  longint'(m_count[d]));
        check({tag, ".out_overflow"}, ov,  longint'(m_oo[d]));
    endtask

    task automatic compare_all();
        cmp_dut(0, "a", a_in_ready, a_out_valid, a_out_sum, a_out_count, a_out_overflow);
        cmp_dut(1, "b", b_in_ready, b_out_valid, b_out_sum, b_out_count, b_out_overflow);
    endtask

    // One clock: apply inputs, compare mid-cycle, return just after the edge.
    task automatic cyc(input bit v, input int p, input bit l, input bit i,
                       input int ai, input bit ordy, input bit fl);
        in_valid = v; in_product = p[15:0]; in_last = l; init_en = i;
        acc_init = ai[23:0]; out_ready = ordy; flush = fl;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int p, input bit l);
        cyc(1'b1, p, l, 1'b0, 0, 1'b1, 1'b0);
    endtask

    task automatic idle(input bit ordy);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, ordy, 1'b0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, " a.out_valid"}, a_out_valid, 0);
        check({tag, " a.out_sum"},   a_out_sum, 0);
        check({tag, " a.out_count"}, a_out_count, 0);
        check({tag, " b.out_valid"}, b_out_valid, 0);
        check({tag, " b.out_sum"},   b_out_sum, 0);
        check({tag, " b.out_overflow"}, b_out_overflow, 0);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_cleared(tag);
        idle(1'b1);
        idle(1'b1);
        rst_n = 1'b1;
        idle(1'b1);
    endtask

    initial begin
        #2;
        apply_reset("reset");

        // Plain three-beat dot product.
        beat(3, 0); beat(5, 0); beat(7, 1);
        check("dp1 valid", a_out_valid, 1);
        check("dp1 sum",   a_out_sum, 15);
        check("dp1 count", a_out_count, 3);
        check("dp1 ovf",   a_out_overflow, 0);

        // Seeded dot product, then a single-beat one back-to-back.
        cyc(1'b1, 2, 1'b0, 1'b1, 100, 1'b1, 1'b0);
        cyc(1'b1, 3, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        check("seed sum",   a_out_sum, 105);
        check("seed count", a_out_count, 2);
        beat(4, 1);
        check("b2b valid", a_out_valid, 1);
        check("b2b sum",   a_out_sum, 4);
        check("b2b count", b_out_count, 1);
        idle(1'b1);

        // Backpressure: held result blocks new beats until drained.
        beat(3, 0); beat(5, 0); beat(7, 1);
        cyc(1'b1, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        check("bp in_ready", a_in_ready, 0);
        check("bp sum",      a_out_sum, 15);
        check("bp count",    a_out_count, 3);
        beat(1, 0);
        beat(2, 1);
        check("bp2 valid", a_out_valid, 1);
        check("bp2 sum",   a_out_sum, 3);
        check("bp2 count", a_out_count, 2);
        idle(1'b1);

        // Wrap in the guardless configuration only.
        beat(16'hFFFF, 0); beat(2, 1);
        check("wrap b sum", b_out_sum, 1);
        check("wrap b ovf", b_out_overflow, 1);
        check("wrap a sum", a_out_sum, 32'h10001);
        check("wrap a ovf", a_out_overflow, 0);

        // MAX_K forced termination in the MAX_K=4 configuration.
        beat(1, 0); beat(1, 0); beat(1, 0); beat(1, 0);
        check("maxk valid", b_out_valid, 1);
        check("maxk sum",   b_out_sum, 4);
        check("maxk count", b_out_count, 4);
        check("maxk ovf",   b_out_overflow, 1);
        beat(1, 0); beat(1, 1);
        check("maxk next sum",   b_out_sum, 2);
        check("maxk next count", b_out_count, 2);
        check("maxk a sum",      a_out_sum, 6);
        idle(1'b1);

        // Flush discards partial work; a held result survives a flush.
        beat(10, 0); beat(20, 0);
        cyc(1'b1, 99, 1'b0, 1'b0, 0, 1'b1, 1'b1);
        beat(5, 1);
        check("flush sum",   a_out_sum, 5);
        check("flush count", a_out_count, 1);
        cyc(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("flush held valid", a_out_valid, 1);
        check("flush held sum",   a_out_sum, 5);
        idle(1'b1);

        // Reset mid-accumulation and with a result held.
        beat(6, 0); beat(7, 0);
        apply_reset("rst mid");
        beat(6, 1);
        check("post rst sum",   a_out_sum, 6);
        check("post rst count", a_out_count, 1);
        beat(9, 1);
        apply_reset("rst held");

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            int p;
            p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16'hFF00, 16'hFFFF))
                                            : int'($urandom_range(0, 16'hFFFF));
            cyc($urandom_range(0, 3) != 0, p, $urandom_range(0, 4) == 0,
                $urandom_range(0, 1) == 1, int'($urandom()),
                $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
